// File: rtl/hram_arb.sv
// Two-requester round-robin arbiter in front of a single PSRAM controller port.
// Latches the winning request, waits for completion or timeout, and steers read data back.
module hram_arb #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        grant,
  output logic        busy,
  output logic        err
);

  // state    | meaning
  // IDLE     | no transaction; arbitrates and latches the winner on the same edge
  // ISSUE    | mem_valid held; waiting for mem_ready or the timeout count
  // RESP     | ready pulse to the owner is visible this cycle
  // RELEASE  | waiting for the controller to drop mem_ready
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RESP,
    ST_RELEASE
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic        winner;
  logic        do_load;
  logic        do_done;
  logic        do_timeout;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    do_load    = 1'b0;
    do_done    = 1'b0;
    do_timeout = 1'b0;
    // a lone requester wins outright; a tie goes to the port that did not own last
    winner     = (m0_valid && m1_valid) ? ~grant : m1_valid;
    case (state)
      ST_IDLE: begin
        if (m0_valid || m1_valid) begin
          do_load   = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_ready) begin
          do_done   = 1'b1;
          state_nxt = ST_RESP;
        end else if (cnt == CNT_LAST) begin
          do_done    = 1'b1;
          do_timeout = 1'b1;
          state_nxt  = ST_RESP;
        end
      end
      ST_RESP: state_nxt = ST_RELEASE;
      ST_RELEASE: begin
        if (!mem_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      m0_ready  <= 1'b0;
      m1_ready  <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      grant     <= 1'b1;
      err       <= 1'b0;
      cnt       <= '0;
    end else begin
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      if (state == ST_ISSUE) cnt <= cnt + 16'd1;
      if (do_load) begin
        mem_valid <= 1'b1;
        grant     <= winner;
        cnt       <= '0;
        mem_addr  <= winner ? m1_addr  : m0_addr;
        mem_wdata <= winner ? m1_wdata : m0_wdata;
        mem_wstrb <= winner ? m1_wstrb : m0_wstrb;
      end
      if (do_done) begin
        mem_valid <= 1'b0;
        if (grant) begin
          m1_ready <= 1'b1;
          m1_rdata <= do_timeout ? 32'hFFFF_FFFF : mem_rdata;
        end else begin
          m0_ready <= 1'b1;
          m0_rdata <= do_timeout ? 32'hFFFF_FFFF : mem_rdata;
        end
        if (do_timeout) err <= 1'b1;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_hram_arb.sv
// Self-checking bench for hram_arb: randomized requesters and controller against a
// transaction-level round-robin model, plus directed cases and a short-timeout instance.
module tb_hram_arb;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        m0_valid, m1_valid, m0_ready, m1_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb, mem_wstrb;
  logic        mem_valid, mem_ready, grant, busy, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        t_reset;
  logic        t_m0_valid, t_m1_valid, t_m0_ready, t_m1_ready;
  logic [31:0] t_m0_addr, t_m0_wdata, t_m0_rdata, t_m1_addr, t_m1_wdata, t_m1_rdata;
  logic [3:0]  t_m0_wstrb, t_m1_wstrb, t_mem_wstrb;
  logic        t_mem_valid, t_mem_ready, t_grant, t_busy, t_err;
  logic [31:0] t_mem_addr, t_mem_wdata, t_mem_rdata;

  hram_arb dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant(grant), .busy(busy), .err(err)
  );

  hram_arb #(.TIMEOUT(TO)) dut8 (
    .clk(clk), .reset(t_reset),
    .m0_valid(t_m0_valid), .m0_addr(t_m0_addr), .m0_wdata(t_m0_wdata), .m0_wstrb(t_m0_wstrb),
    .m0_rdata(t_m0_rdata), .m0_ready(t_m0_ready),
    .m1_valid(t_m1_valid), .m1_addr(t_m1_addr), .m1_wdata(t_m1_wdata), .m1_wstrb(t_m1_wstrb),
    .m1_rdata(t_m1_rdata), .m1_ready(t_m1_ready),
    .mem_valid(t_mem_valid), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
    .mem_wstrb(t_mem_wstrb), .mem_rdata(t_mem_rdata), .mem_ready(t_mem_ready),
    .grant(t_grant), .busy(t_busy), .err(t_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // stimulus knobs
  bit          gen_en[2];
  int          gen_pct = 0;
  int          fixed_lat = -1;
  bit          data_ovr = 1'b0;
  logic [31:0] data_val = '0;
  int          req_n[2], done_n[2], rcnt[2];
  int          ghist[$];

  task automatic issue(input int p, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (p == 0) begin m0_addr = a; m0_wdata = d; m0_wstrb = s; m0_valid = 1'b1; end
    else        begin m1_addr = a; m1_wdata = d; m1_wstrb = s; m1_valid = 1'b1; end
    req_n[p]++;
  endtask

  // requesters: drop valid the cycle after ready, optionally raise new random requests
  initial begin
    m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    forever begin
      @(negedge clk);
      if (m0_valid && m0_ready) begin m0_valid = 1'b0; done_n[0]++; end
      else if (!m0_valid && gen_en[0] && int'($urandom_range(99, 0)) < gen_pct)
        issue(0, $urandom, $urandom, 4'($urandom));
      if (m1_valid && m1_ready) begin m1_valid = 1'b0; done_n[1]++; end
      else if (!m1_valid && gen_en[1] && int'($urandom_range(99, 0)) < gen_pct)
        issue(1, $urandom, $urandom, 4'($urandom));
    end
  end

  // PSRAM controller: ready after a latency, held until mem_valid drops
  initial begin
    bit active;
    int wc;
    active = 0; wc = 0;
    mem_ready = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!mem_valid) begin
        mem_ready = 1'b0;
        active = 0;
      end else begin
        if (!active) begin
          active = 1;
          wc = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(4, 0));
        end
        if (!mem_ready) begin
          if (wc == 0) begin
            mem_ready = 1'b1;
            mem_rdata = data_ovr ? data_val : $urandom;
          end else wc--;
        end
      end
    end
  end

  // transaction-level reference: round-robin owner, latched request, returned data
  logic        prev_mv;
  bit          outst;
  int          exp_p, last_g;
  logic [31:0] rd_m[2];
  logic [31:0] ea, ew;
  logic [3:0]  es;
  initial begin
    prev_mv = 0; outst = 0; exp_p = 0; last_g = 1; rd_m[0] = 0; rd_m[1] = 0;
    ea = 0; ew = 0; es = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        prev_mv = 0; outst = 0; last_g = 1; rd_m[0] = 0; rd_m[1] = 0;
      end else begin
        if (mem_valid && !prev_mv) begin
          check("issue_while_outstanding", outst, 0);
          check("issue_needs_request", m0_valid || m1_valid, 1);
          exp_p = (m0_valid && m1_valid) ? 1 - last_g : (m1_valid ? 1 : 0);
          ea = exp_p ? m1_addr : m0_addr;
          ew = exp_p ? m1_wdata : m0_wdata;
          es = exp_p ? m1_wstrb : m0_wstrb;
          check("grant_winner", grant, exp_p);
          check("mem_addr", mem_addr, ea);
          check("mem_wdata", mem_wdata, ew);
          check("mem_wstrb", mem_wstrb, es);
          ghist.push_back(int'(grant));
          last_g = exp_p;
          outst = 1;
        end else if (mem_valid) begin
          check("mem_addr_stable", mem_addr, ea);
          check("mem_wdata_stable", mem_wdata, ew);
          check("mem_wstrb_stable", mem_wstrb, es);
        end
        if (m0_ready || m1_ready) begin
          check("ready_expected", outst, 1);
          check("ready_port", {m1_ready, m0_ready}, exp_p ? 2'b10 : 2'b01);
          rd_m[exp_p] = mem_rdata;
          if (m0_ready) rcnt[0]++;
          if (m1_ready) rcnt[1]++;
          outst = 0;
        end
        if (mem_valid || m0_ready || m1_ready) check("busy_active", busy, 1);
        check("m0_rdata", m0_rdata, rd_m[0]);
        check("m1_rdata", m1_rdata, rd_m[1]);
        prev_mv = mem_valid;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; m0_valid = 1'b0; m1_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_done(input int p, input int target, input int bound, input string tag);
    int n = 0;
    while (done_n[p] < target && n < bound) begin @(negedge clk); n++; end
    check(tag, done_n[p] >= target, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, d1, n, r0, r1;
    int sq[2], sd[2];
    reset = 1'b1; t_reset = 1'b1;
    gen_en[0] = 0; gen_en[1] = 0;
    t_m0_valid = 0; t_m0_addr = 0; t_m0_wdata = 0; t_m0_wstrb = 0;
    t_m1_valid = 0; t_m1_addr = 0; t_m1_wdata = 0; t_m1_wstrb = 0;
    t_mem_ready = 0; t_mem_rdata = 0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_wstrb", mem_wstrb, 0);
    check("rst_ready", {m1_ready, m0_ready}, 0);
    check("rst_rdata", {m1_rdata, m0_rdata}, 0);
    check("rst_grant", grant, 1);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0; t_reset = 1'b0;

    // lone m0 read, slow controller
    do_reset();
    rcnt[0] = 0; rcnt[1] = 0;
    fixed_lat = 19; data_ovr = 1; data_val = 32'h1234_5678;
    d0 = done_n[0];
    issue(0, 32'h100, 32'h0, 4'h0);
    @(negedge clk);
    check("latency_mem_valid", mem_valid, 1);
    check("busy_issue", busy, 1);
    check("m0_read_addr", mem_addr, 32'h100);
    wait_done(0, d0 + 1, 100, "m0_read_done");
    repeat (3) @(negedge clk);
    check("m0_read_pulses", rcnt[0], 1);
    check("m0_read_m1_pulses", rcnt[1], 0);
    check("m0_read_grant", grant, 0);
    check("m0_read_rdata", m0_rdata, 32'h1234_5678);
    data_ovr = 0;

    // simultaneous requests after reset
    do_reset();
    ghist.delete(); rcnt[0] = 0; rcnt[1] = 0; fixed_lat = -1;
    d0 = done_n[0]; d1 = done_n[1];
    issue(0, $urandom, $urandom, 4'h0);
    issue(1, $urandom, $urandom, 4'hF);
    wait_done(0, d0 + 1, 100, "tie_m0_done");
    wait_done(1, d1 + 1, 100, "tie_m1_done");
    repeat (3) @(negedge clk);
    check("tie_grants", ghist.size(), 2);
    if (ghist.size() == 2) begin
      check("tie_first", ghist[0], 0);
      check("tie_second", ghist[1], 1);
    end
    check("tie_m0_pulses", rcnt[0], 1);
    check("tie_m1_pulses", rcnt[1], 1);

    // m1 write, request held until mem_ready
    fixed_lat = 5;
    d1 = done_n[1];
    issue(1, 32'h40, 32'hA5A5_A5A5, 4'b0011);
    @(negedge clk);
    check("wr_mem_valid", mem_valid, 1);
    check("wr_mem_addr", mem_addr, 32'h40);
    check("wr_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
    check("wr_mem_wstrb", mem_wstrb, 4'b0011);
    repeat (3) @(negedge clk);
    check("wr_hold_valid", mem_valid, 1);
    check("wr_hold_addr", mem_addr, 32'h40);
    check("wr_hold_wstrb", mem_wstrb, 4'b0011);
    wait_done(1, d1 + 1, 100, "wr_done");
    check("wr_grant", grant, 1);

    // continuous back-to-back requests alternate
    ghist.delete(); fixed_lat = -1; gen_pct = 100;
    gen_en[0] = 1; gen_en[1] = 1;
    n = 0;
    while (ghist.size() < 8 && n < 300) begin @(negedge clk); n++; end
    gen_en[0] = 0; gen_en[1] = 0;
    check("rr_count", ghist.size() >= 8, 1);
    for (int i = 0; i < 8 && i < ghist.size(); i++) check("rr_alternate", ghist[i], i % 2);
    n = 0;
    while ((m0_valid || m1_valid || busy) && n < 200) begin @(negedge clk); n++; end

    // random traffic, nothing dropped
    sq[0] = req_n[0]; sq[1] = req_n[1]; sd[0] = done_n[0]; sd[1] = done_n[1];
    gen_pct = 30; gen_en[0] = 1; gen_en[1] = 1;
    repeat (400) @(negedge clk);
    gen_en[0] = 0; gen_en[1] = 0;
    n = 0;
    while ((m0_valid || m1_valid || busy) && n < 200) begin @(negedge clk); n++; end
    check("rand_drained", m0_valid || m1_valid || busy, 0);
    check("rand_m0_served", done_n[0] - sd[0], req_n[0] - sq[0]);
    check("rand_m1_served", done_n[1] - sd[1], req_n[1] - sq[1]);

    // reset during ISSUE
    fixed_lat = 30;
    r0 = rcnt[0]; r1 = rcnt[1];
    issue(1, $urandom, $urandom, 4'h0);
    n = 0;
    while (!mem_valid && n < 20) begin @(negedge clk); n++; end
    check("mid_rst_issued", mem_valid, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1; m1_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_mem_valid", mem_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_grant", grant, 1);
    check("mid_rst_ready", {m1_ready, m0_ready}, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_no_pulse", (rcnt[0] - r0) + (rcnt[1] - r1), 0);
    fixed_lat = -1;

    // timeout on the TIMEOUT=8 instance
    t_m0_addr = 32'h200; t_m0_wstrb = 4'h0; t_m0_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (t_m0_ready) break;
      if (t_mem_valid) n++;
    end
    check("to_issue_cycles", n, TO);
    check("to_ready", t_m0_ready, 1);
    check("to_rdata", t_m0_rdata, 32'hFFFF_FFFF);
    check("to_err", t_err, 1);
    check("to_m1_ready", t_m1_ready, 0);
    check("to_mem_valid", t_mem_valid, 0);
    t_m0_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("to_err_sticky", t_err, 1);
    check("to_pulse_once", t_m0_ready, 0);
    t_m1_addr = 32'h300; t_m1_wdata = 32'h0; t_m1_wstrb = 4'h0; t_m1_valid = 1'b1;
    @(negedge clk);
    check("to_next_issue", t_mem_valid, 1);
    check("to_next_grant", t_grant, 1);
    check("to_next_addr", t_mem_addr, 32'h300);
    repeat (2) @(negedge clk);
    t_mem_rdata = 32'hCAFE_F00D; t_mem_ready = 1'b1;
    @(negedge clk);
    check("to_next_ready", t_m1_ready, 1);
    check("to_next_rdata", t_m1_rdata, 32'hCAFE_F00D);
    check("to_m0_rdata_hold", t_m0_rdata, 32'hFFFF_FFFF);
    check("to_next_mem_valid", t_mem_valid, 0);
    t_m1_valid = 1'b0;
    @(negedge clk);
    t_mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("to_err_still", t_err, 1);
    check("to_idle", t_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hram_arb.md
HRAM_ARB -- requirements
Module: hram_arb

Interface
REQ-001 Parameter TIMEOUT, default 1024: cycles allowed in ISSUE before forced completion; legal range 2..65535.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 m0_valid / m1_valid  in  1  requester N transaction request, held until mN_ready.
REQ-005 m0_addr / m1_addr  in  32  requester N byte address.
REQ-006 m0_wdata / m1_wdata  in  32  requester N write data.
REQ-007 m0_wstrb / m1_wstrb  in  4  requester N byte strobes; 0 = read.
REQ-008 m0_rdata / m1_rdata  out  32  requester N read data, valid while mN_ready=1.
REQ-009 m0_ready / m1_ready  out  1  requester N completion, one-cycle pulse.
REQ-010 mem_valid  out  1  request to PSRAM controller.
REQ-011 mem_addr / mem_wdata  out  32  latched address / write data.
REQ-012 mem_wstrb  out  4  latched strobes.
REQ-013 mem_rdata  in  32  controller read data.
REQ-014 mem_ready  in  1  controller completion; held high until mem_valid drops.
REQ-015 grant  out  1  index of current/last owner.
REQ-016 busy  out  1  high in any state except IDLE.
REQ-017 err  out  1  sticky timeout flag.

Function
REQ-018 FSM states: IDLE, ISSUE, RESP, RELEASE.
REQ-019 IDLE: if any mN_valid is high, select winner, latch its addr/wdata/wstrb into mem_* and set grant, assert mem_valid, and go to ISSUE, all on one edge.
REQ-020 Latency: mem_valid is high the cycle after the winning mN_valid is first sampled high in IDLE.
REQ-021 Arbitration: single requester wins; both high -> port != grant wins (round-robin); winner updates grant.
REQ-022 ISSUE: mem_valid and mem_* are held stable; a 16-bit counter increments each cycle.
REQ-023 ISSUE with mem_ready=1: on the same edge, copy mem_rdata to m<grant>_rdata, pulse m<grant>_ready for one cycle, clear mem_valid, and go to RESP.
REQ-024 ISSUE with counter == TIMEOUT-1 and mem_ready=0: on the same edge, set m<grant>_rdata=32'hFFFFFFFF, pulse m<grant>_ready, clear mem_valid, set err=1, and go to RESP.
REQ-025 RESP: deassert mN_ready and go to RELEASE next cycle.
REQ-026 RELEASE: wait until mem_ready=0, then go to IDLE; no new grant while mem_ready=1.
REQ-027 The losing requester's valid remains pending and is granted in the next IDLE cycle; it is never dropped.
REQ-028 The non-granted mN_ready SHALL stay 0; its mN_rdata SHALL hold its last value.
REQ-029 mN_valid changes outside IDLE are ignored until the next IDLE sample.
REQ-030 Requesters SHALL deassert valid within one cycle of ready; the arbiter does not qualify this.
REQ-031 The minimum transaction period is 4 cycles (IDLE, ISSUE, RESP, RELEASE) when mem_ready rises the first ISSUE cycle and falls one cycle after mem_valid.

Reset
REQ-032 Reset SHALL force state=IDLE, mem_valid=0, mem_addr/mem_wdata=0, mem_wstrb=0, m0_ready=m1_ready=0, m0_rdata=m1_rdata=0, grant=1 (port 0 wins the first tie), err=0, counter=0.
REQ-033 Reset asserted mid-transaction SHALL drop mem_valid on the same edge without pulsing any mN_ready.
REQ-034 err is cleared only by reset.

Verification
REQ-035 m0 read addr 0x100 alone, controller returns 0x12345678 after 20 cycles -> m0_ready one pulse with m0_rdata=0x12345678; m1_ready=0; grant=0.
REQ-036 m0 and m1 valid on the same cycle after reset -> m0 served first, then m1; grant sequence 0,1; each requester gets exactly one ready pulse.
REQ-037 m0 and m1 requesting back-to-back continuously -> grants alternate 0,1,0,1 over 8 transactions; no starvation.
REQ-038 m1 write addr 0x40, wdata 0xA5A5A5A5, wstrb 4'b0011 -> mem_addr=0x40, mem_wdata=0xA5A5A5A5, mem_wstrb=0011, held stable until mem_ready.
REQ-039 TIMEOUT=8 with controller mem_ready stuck at 0 -> after 8 ISSUE cycles, mN_ready pulses with rdata 0xFFFFFFFF, err=1 and stays 1; the next request proceeds normally.
REQ-040 Reset asserted during ISSUE -> the next cycle shows mem_valid=0, busy=0, grant=1, and no ready pulse.
